// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Purpose:
//   Programmable raster timing generator for the video path. A horizontal and
//   a vertical counter advance on the pixel clock enable and are decoded into
//   sync, blanking, data-enable and line/frame start pulses for the downstream
//   mixer and pixel sources. Because the counters only move on ce_pix_i, one
//   clk_vid can serve several dot rates.
//
// Optional feature:
//   VIDEO_TIMING_INTERLACE_EN - when defined, interlace_req_i is sampled at
//   every frame wrap. While interlaced, field_o alternates every frame, and
//   odd fields carry one extra blank line at vcount = V_TOTAL. When undefined,
//   field_o and interlaced_o stay 0 and interlace_req_i is ignored.
//
// Ports:
//   clk_vid          in   pixel-domain clock
//   reset            in   synchronous, active-high reset
//   ce_pix_i         in   pixel clock enable; nothing advances while it is 0
//   interlace_req_i  in   interlace request, sampled at frame wrap
//   hcount_o         out  current pixel column (HW bits)
//   vcount_o         out  current line (VW bits)
//   hs_o / vs_o      out  horizontal / vertical sync, active-high
//   hb_o / vb_o      out  horizontal / vertical blank
//   de_o             out  data enable (~hb & ~vb)
//   line_start_o     out  one-cycle pulse when hcount enters 0
//   frame_start_o    out  one-cycle pulse when (hcount,vcount) enters (0,0)
//   field_o          out  0 = even field, 1 = odd field
//   interlaced_o     out  1 while interlace mode is active
//
// Every output is a register loaded from the next-state counters, so it
// reflects the counter value loaded on the same edge that sampled ce_pix_i.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 15,
  parameter int HW       = 10,
  parameter int VW       = 9
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix_i,
  input  logic          interlace_req_i,
  output logic [HW-1:0] hcount_o,
  output logic [VW-1:0] vcount_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          hb_o,
  output logic          vb_o,
  output logic          de_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          field_o,
  output logic          interlaced_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST_EVEN = VW'(V_TOTAL - 1);

  // Decode thresholds carry one extra bit so that an end-of-range value equal
  // to 2^HW (or 2^VW) does not alias to 0 and break the compare.
  localparam logic [HW:0] HB_START = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_START = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] VB_START = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_START = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VIDEO_TIMING_INTERLACE_EN
  // Odd interlaced fields run one extra (blank) line.
  localparam logic [VW-1:0] V_LAST_ODD = VW'(V_TOTAL);
`endif

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          hb_q, hb_d;
  logic          vb_q, vb_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          field_q, field_d;
  logic          interlaced_q, interlaced_d;

  logic [VW-1:0] last_line;
  logic          h_wrap;
  logic          v_wrap;

`ifndef VIDEO_TIMING_INTERLACE_EN
  // Port kept for a uniform interface; it has no effect in this build.
  logic unused_interlace_req;
  assign unused_interlace_req = interlace_req_i;
`endif

  always_comb begin
`ifdef VIDEO_TIMING_INTERLACE_EN
    last_line = (interlaced_q && field_q) ? V_LAST_ODD : V_LAST_EVEN;
`else
    last_line = V_LAST_EVEN;
`endif
    h_wrap = (hcount_q == H_LAST);
    v_wrap = (vcount_q == last_line);

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    field_d       = field_q;
    interlaced_d  = interlaced_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (ce_pix_i) begin
      if (h_wrap) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (v_wrap) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
`ifdef VIDEO_TIMING_INTERLACE_EN
          // The mode is only allowed to change on a frame boundary; field
          // toggles under interlace and is parked at even otherwise.
          interlaced_d = interlace_req_i;
          field_d      = interlace_req_i & ~field_q;
`endif
        end else begin
          vcount_d = vcount_q + 1'b1;
        end
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end

    // Levels decode the next-state counters so they line up with the
    // registered counter outputs. vs only follows vcount, which itself only
    // moves when hcount wraps to 0.
    hb_d = ({1'b0, hcount_d} >= HB_START);
    hs_d = ({1'b0, hcount_d} >= HS_START) && ({1'b0, hcount_d} < HS_END);
    vb_d = ({1'b0, vcount_d} >= VB_START);
    vs_d = ({1'b0, vcount_d} >= VS_START) && ({1'b0, vcount_d} < VS_END);
    de_d = ~hb_d & ~vb_d;
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST_EVEN;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hb_q          <= 1'b1;
      vb_q          <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      field_q       <= 1'b0;
      interlaced_q  <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hb_q          <= hb_d;
      vb_q          <= vb_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      field_q       <= field_d;
      interlaced_q  <= interlaced_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign hb_o          = hb_q;
  assign vb_o          = vb_q;
  assign de_o          = de_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign field_o       = field_q;
  assign interlaced_o  = interlaced_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two generators share clock and stimulus: u_def with the default 400x262
// raster, and u_small with a 16x11 raster (hcount width exactly fills 4 bits)
// so that whole frames fit in a short run. A raster model tracks each one
// and is compared against every output on every clk_vid cycle; directed
// phases add literal checks on reset, first edge, line/frame periods and a
// mid-frame reset.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  logic clk_vid = 1'b0;
  logic reset   = 1'b1;
  logic ce_pix  = 1'b1;
  logic ireq    = 1'b1;

  always #5 clk_vid = ~clk_vid;

  logic [9:0] h0;
  logic [8:0] v0;
  logic hs0, vs0, hb0, vb0, de0, ls0, fs0, f0, il0;
  logic [3:0] h1;
  logic [3:0] v1;
  logic hs1, vs1, hb1, vb1, de1, ls1, fs1, f1, il1;

  video_timing_gen u_def (
    .clk_vid(clk_vid), .reset(reset), .ce_pix_i(ce_pix), .interlace_req_i(ireq),
    .hcount_o(h0), .vcount_o(v0), .hs_o(hs0), .vs_o(vs0), .hb_o(hb0), .vb_o(vb0),
    .de_o(de0), .line_start_o(ls0), .frame_start_o(fs0), .field_o(f0),
    .interlaced_o(il0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HW(4), .VW(4)
  ) u_small (
    .clk_vid(clk_vid), .reset(reset), .ce_pix_i(ce_pix), .interlace_req_i(ireq),
    .hcount_o(h1), .vcount_o(v1), .hs_o(hs1), .vs_o(vs1), .hb_o(hb1), .vb_o(vb1),
    .de_o(de1), .line_start_o(ls1), .frame_start_o(fs1), .field_o(f1),
    .interlaced_o(il1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Raster parameters per instance: 0 = u_def, 1 = u_small.
  int p_ha [2] = '{320, 8};
  int p_hfp[2] = '{8, 2};
  int p_hsy[2] = '{32, 3};
  int p_hbp[2] = '{40, 3};
  int p_va [2] = '{240, 6};
  int p_vfp[2] = '{1 + 3, 1};
  int p_vsy[2] = '{3, 2};
  int p_vbp[2] = '{15, 2};

  // Model state: raster position, field/interlace and this cycle's pulses.
  int mh[2], mv[2];
  bit mf[2], mi[2], mls[2], mfs[2];

  // Inputs as seen by the active edge.
  logic s_reset, s_ce, s_req;
  bit   s_valid = 1'b0;
  always @(posedge clk_vid) begin
    s_reset <= reset;
    s_ce    <= ce_pix;
    s_req   <= ireq;
    s_valid <= 1'b1;
  end

  task automatic cmp_inst(input int k, input logic [31:0] h, input logic [31:0] v,
                          input logic hs, input logic vs, input logic hb,
                          input logic vb, input logic de, input logic ls,
                          input logic fs, input logic fld, input logic il);
    bit e_hb, e_vb, e_hs, e_vs;
    e_hb = (mh[k] >= p_ha[k]);
    e_vb = (mv[k] >= p_va[k]);
    e_hs = (mh[k] >= p_ha[k] + p_hfp[k]) && (mh[k] < p_ha[k] + p_hfp[k] + p_hsy[k]);
    e_vs = (mv[k] >= p_va[k] + p_vfp[k]) && (mv[k] < p_va[k] + p_vfp[k] + p_vsy[k]);
    check("hcount", k, h, mh[k]);
    check("vcount", k, v, mv[k]);
    check("hs", k, {31'd0, hs}, {31'd0, e_hs});
    check("vs", k, {31'd0, vs}, {31'd0, e_vs});
    check("hb", k, {31'd0, hb}, {31'd0, e_hb});
    check("vb", k, {31'd0, vb}, {31'd0, e_vb});
    check("de", k, {31'd0, de}, {31'd0, !e_hb && !e_vb});
    check("line_start", k, {31'd0, ls}, {31'd0, mls[k]});
    check("frame_start", k, {31'd0, fs}, {31'd0, mfs[k]});
    check("field", k, {31'd0, fld}, {31'd0, mf[k]});
    check("interlaced", k, {31'd0, il}, {31'd0, mi[k]});
  endtask

  // Model step and per-cycle compare, half a period after each active edge.
  initial begin
    int ht, vt, last;
    forever begin
      @(negedge clk_vid);
      if (s_valid) begin
        for (int k = 0; k < 2; k++) begin
          ht = p_ha[k] + p_hfp[k] + p_hsy[k] + p_hbp[k];
          vt = p_va[k] + p_vfp[k] + p_vsy[k] + p_vbp[k];
          mls[k] = 1'b0;
          mfs[k] = 1'b0;
          if (s_reset === 1'b1) begin
            mh[k] = ht - 1;
            mv[k] = vt - 1;
            mf[k] = 1'b0;
            mi[k] = 1'b0;
          end else if (s_ce === 1'b1) begin
            last = (mi[k] && mf[k]) ? vt : vt - 1;
            mh[k] = (mh[k] + 1) % ht;
            if (mh[k] == 0) begin
              mls[k] = 1'b1;
              mv[k] = (mv[k] == last) ? 0 : mv[k] + 1;
              if (mv[k] == 0) begin
                mfs[k] = 1'b1;
`ifdef VIDEO_TIMING_INTERLACE_EN
                mi[k] = s_req;
                mf[k] = s_req ? !mf[k] : 1'b0;
`endif
              end
            end
          end
        end
        cmp_inst(0, 32'(h0), 32'(v0), hs0, vs0, hb0, vb0, de0, ls0, fs0, f0, il0);
        cmp_inst(1, 32'(h1), 32'(v1), hs1, vs1, hb1, vb1, de1, ls1, fs1, f1, il1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int cyc    = 0;
  int ce_div = 1;   // 0 holds ce_pix low, N gives one enable every N cycles

  task automatic tick();
    @(negedge clk_vid);
    cyc++;
    if (ce_div == 0) ce_pix = 1'b0;
    else             ce_pix = ((cyc % ce_div) == 0);
  endtask

  task automatic wait_fs1(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (fs1 !== 1'b1 && n < bound);
  endtask

  initial begin
    int n, n_a, n_b, hs_cnt, hb_rise, hs_rise, vmax;
    logic prev_hb, prev_hs;

    // Reset held for five edges with ce_pix high.
    repeat (5) tick();
    check("rst_hcount", 0, 32'(h0), 399);
    check("rst_vcount", 0, 32'(v0), 261);
    check("rst_hb_vb_de", 0, {29'd0, hb0, vb0, de0}, 32'b110);
    check("rst_hcount", 1, 32'(h1), 15);
    check("rst_vcount", 1, 32'(v1), 10);

    // First enabled edge lands on (0,0) with both pulses and de.
    reset = 1'b0;
    tick();
    check("first_pos", 0, {22'd0, h0} | {v0, 10'd0}, 0);
    check("first_pulses_de", 0, {29'd0, fs0, ls0, de0}, 32'b111);
    check("first_pos", 1, {24'd0, v1, h1}, 0);
    check("first_pulses_de", 1, {29'd0, fs1, ls1, de1}, 32'b111);

    // One full line of the default raster.
    n = 0; hs_cnt = 0; hb_rise = -1; hs_rise = -1;
    prev_hb = hb0; prev_hs = hs0;
    do begin
      tick();
      n++;
      if (hs0 === 1'b1) hs_cnt++;
      if (hb0 === 1'b1 && prev_hb === 1'b0) hb_rise = int'(h0);
      if (hs0 === 1'b1 && prev_hs === 1'b0) hs_rise = int'(h0);
      prev_hb = hb0; prev_hs = hs0;
    end while (ls0 !== 1'b1 && n < 1000);
    check("line_period", 0, n, 400);
    check("hb_rise_h", 0, hb_rise, 320);
    check("hs_rise_h", 0, hs_rise, 328);
    check("hs_width", 0, hs_cnt, 32);
    check("line1_v", 0, 32'(v0), 1);

    // Two consecutive frames of the small raster at full rate.
    wait_fs1(1000, n);
    check("fs_align", 1, {31'd0, fs1}, 1);
    vmax = 0;
    n_a = 0;
    do begin tick(); n_a++; if (int'(v1) > vmax) vmax = int'(v1); end
    while (fs1 !== 1'b1 && n_a < 1000);
    n_b = 0;
    do begin tick(); n_b++; if (int'(v1) > vmax) vmax = int'(v1); end
    while (fs1 !== 1'b1 && n_b < 1000);
`ifdef VIDEO_TIMING_INTERLACE_EN
    check("two_frames", 1, n_a + n_b, 368);
    check("vcount_max", 1, vmax, 11);
    check("interlaced_on", 1, {31'd0, il1}, 1);
`else
    check("frame_period", 1, n_a, 176);
    check("frame_period", 1, n_b, 176);
    check("vcount_max", 1, vmax, 10);
    check("field_il_off", 1, {30'd0, f1, il1}, 0);
`endif

    // Reset in the middle of the default frame.
    n = 0;
    while (!(h0 == 10'd150 && v0 == 9'd100) && n < 60000) begin
      tick();
      n++;
    end
    check("reach_150_100", 0, {31'd0, (h0 == 10'd150 && v0 == 9'd100)}, 1);
    reset = 1'b1;
    tick();
    check("midrst_pos", 0, {22'd0, h0} | {v0, 10'd0}, {9'd261, 10'd399});
    check("midrst_levels", 0, {26'd0, hb0, vb0, de0, hs0, vs0, fs0}, 32'b110000);
    reset = 1'b0;
    tick();
    check("resume_pos", 0, {22'd0, h0} | {v0, 10'd0}, 0);
    check("resume_fs", 0, {30'd0, fs0, ls0}, 32'b11);

    // Quarter-rate enable on the small raster.
    ce_div = 4;
    wait_fs1(3000, n);
    check("fs_align_div4", 1, {31'd0, fs1}, 1);
    wait_fs1(3000, n_a);
    wait_fs1(3000, n_b);
`ifdef VIDEO_TIMING_INTERLACE_EN
    check("two_frames_div4", 1, n_a + n_b, 1472);
`else
    check("frame_period_div4", 1, n_a, 704);
    check("frame_period_div4", 1, n_b, 704);
`endif

    // Enable held low, then back to full rate.
    ce_div = 0;
    repeat (20) tick();
    ce_div = 1;
    repeat (50) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable raster timing generator that produces the sync, blanking and pixel-position signals for the video path on `clk_vid`. It sits directly upstream of the video mixer: its `hs`/`vs`/`hb`/`vb` feed the mixer's core sync/blank inputs, and its `field`/`interlaced` feed the mixer's interlace inputs. Pixel sources use `hcount`/`vcount`/`de` to fetch RGB. Counters advance only on the pixel clock enable, so one `clk_vid` can serve several dot rates.

## Interface
- `H_ACTIVE`, default 320: visible pixels per line.
- `H_FP`, default 8: horizontal front porch, in pixels.
- `H_SYNC`, default 32: HS width, in pixels.
- `H_BP`, default 40: horizontal back porch, in pixels. H_TOTAL = 400.
- `V_ACTIVE`, default 240: visible lines.
- `V_FP`, default 4: vertical front porch, in lines.
- `V_SYNC`, default 3: VS width, in lines.
- `V_BP`, default 15: vertical back porch, in lines. V_TOTAL = 262.
- `HW`, default 10: hcount width. Must satisfy 2^HW ≥ H_TOTAL.
- `VW`, default 9: vcount width. Must satisfy 2^VW ≥ V_TOTAL+1.

- `clk_vid`, in, 1: pixel-domain clock.
- `reset`, in, 1: synchronous, active-high reset, sampled on `clk_vid`.
- `ce_pix`, in, 1: pixel clock enable. Counters and outputs advance only when it is 1.
- `interlace_req`, in, 1: interlace request, sampled at frame wrap.
- `hcount`, out, HW: current pixel column.
- `vcount`, out, VW: current line.
- `hs`, out, 1: horizontal sync, active-high.
- `vs`, out, 1: vertical sync, active-high.
- `hb`, out, 1: horizontal blank.
- `vb`, out, 1: vertical blank.
- `de`, out, 1: data enable, equal to ~hb & ~vb.
- `line_start`, out, 1: one-`clk_vid` pulse when hcount enters 0.
- `frame_start`, out, 1: one-`clk_vid` pulse when (hcount,vcount) enters (0,0).
- `field`, out, 1: 0 = even field, 1 = odd field.
- `interlaced`, out, 1: 1 while interlace mode is active.

## Operation
- Reset state:
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1.
  - hb = 1, vb = 1, de = 0, hs = 0, vs = 0.
  - line_start = 0, frame_start = 0, field = 0, interlaced = 0.
- Horizontal counter, on each cycle with ce_pix = 1:
  - hcount == H_TOTAL-1 → wrap to 0 and advance vcount.
  - Otherwise hcount+1.
- Vertical counter:
  - vcount == last_line → wrap to 0.
  - Otherwise vcount+1.
  - last_line = V_TOTAL-1, or V_TOTAL when interlaced = 1 and field = 1.
- Decode (all outputs registered from next-state counters):
  - hb = 1 when hcount ≥ H_ACTIVE.
  - hs = 1 when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
  - vb = 1 when vcount ≥ V_ACTIVE.
  - vs = 1 when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC. vs changes only at hcount = 0.
- Pulses:
  - line_start and frame_start are 1 only on the ce_pix cycle that makes the transition.
  - They are 0 on every other cycle, including held cycles.
  - When the frame wraps, both pulse on the same cycle.
- ce_pix = 0: all counters and levels hold their values, and the pulses are 0.
- Reset mid-frame: state returns to the reset values on the next edge; ce_pix is ignored while reset = 1.
- Width rule: counters compare at full width and never exceed H_TOTAL-1 or last_line. Arithmetic wraps to 0, never to 2^HW.

## Timing
- Latency is 0 ce cycles: every output reflects the counter state loaded on the same `clk_vid` edge that sampled ce_pix = 1.
- The first ce_pix after reset produces hcount = 0, vcount = 0, frame_start = 1, line_start = 1, de = 1.
- HS is asserted on H_SYNC ce cycles per line. VS is asserted for exactly V_SYNC full lines.
- HS rises H_FP ce cycles after hb rises, which satisfies the mixer's DE→HS gap rule.

## Configuration
- `VIDEO_TIMING_INTERLACE_EN` defined:
  - At each frame wrap, interlaced ← interlace_req.
  - field toggles when the new interlaced value is 1; otherwise field is forced to 0.
  - Odd fields run V_TOTAL+1 lines; the extra line is blank, at vcount = V_TOTAL.
- `VIDEO_TIMING_INTERLACE_EN` undefined:
  - field = 0 and interlaced = 0 permanently.
  - interlace_req is ignored (the port remains).
  - last_line is always V_TOTAL-1.

## Test plan
- Reset with ce_pix = 1 for 5 cycles, then release → outputs are at reset values during reset; the first enabled edge gives hcount = 0, vcount = 0, frame_start = 1, line_start = 1, de = 1.
- Free-run with ce_pix constant 1 → hb rises at hcount = 320; hs = 1 exactly for hcount 328..359; line_start every 400 cycles.
- Full frame → vb rises at vcount = 240; vs = 1 for vcount 244..246, rising at hcount = 0 of line 244; frame_start every 104800 cycles; vcount max = 261.
- ce_pix = 1 one cycle in 4 → counters advance once per 4 clk_vid cycles; pulses last 1 clk_vid cycle; frame period is 419200 clk_vid cycles.
- Assert reset at hcount = 150, vcount = 100 → next edge returns to the reset state; resumes at (0,0) with frame_start after release.
- With `VIDEO_TIMING_INTERLACE_EN` defined and interlace_req = 1 → after the first wrap, interlaced = 1; field alternates 1,0,1…; odd frames last 263 lines and even frames 262. Without the macro, field = interlaced = 0 throughout.
